imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the instruction memory word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive loader grants in RUN before one fetch grant is forced.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 PC  in  ADDR_W  SHALL be the CPU fetch word address.
REQ-007 Instr  out  DATA_W  SHALL be the fetched instruction word.
REQ-008 Stall  out  1  SHALL hold the CPU PC when high.
REQ-009 LdValid / LdAddr / LdData  in  1 / ADDR_W / DATA_W  SHALL be the loader write request.
REQ-010 LdReady  out  1  SHALL accept a loader write when high with LdValid.
REQ-011 LdDone  in  1  SHALL be a one-cycle pulse marking the end of boot loading.
REQ-012 MemAddr / MemWData / MemWE  out  ADDR_W / DATA_W / 1  SHALL drive the single-port memory.
REQ-013 MemRData  in  DATA_W  SHALL be the memory's combinational read data.
REQ-014 LdCount  out  ADDR_W+1  SHALL count accepted loader writes since reset.

Function
REQ-015 The FSM SHALL have states BOOT, RUN and DRAIN.
REQ-016 In BOOT: Stall=1, LdReady=1, MemAddr=LdAddr, MemWE=LdValid, Instr=0.
REQ-017 BOOT->DRAIN SHALL occur on LdDone; a write in the same cycle as LdDone SHALL still be performed.
REQ-018 DRAIN SHALL last exactly one cycle (Stall=1, LdReady=0, MemWE=0), then go to RUN.
REQ-019 In RUN with LdValid=0: MemAddr=PC, MemWE=0, Instr=MemRData, Stall=0, LdReady=0; fetch latency zero cycles.
REQ-020 In RUN with LdValid=1 and burst counter < MAX_BURST: the loader SHALL be granted (LdReady=1, MemWE=1, MemAddr=LdAddr), Stall=1, Instr held at its last fetched value.
REQ-021 The burst counter SHALL increment per RUN loader grant, saturate at MAX_BURST, and clear on any fetch grant.
REQ-022 When the burst counter equals MAX_BURST, fetch SHALL be granted for one cycle regardless of LdValid.
REQ-023 Fetch of an address written by the loader in the previous cycle SHALL return the new data.
REQ-024 LdCount SHALL increment on every LdValid&&LdReady and saturate at 2^ADDR_W.
REQ-025 LdAddr values SHALL wrap modulo 2^ADDR_W; no range error is flagged.
REQ-026 LdDone in RUN or DRAIN SHALL be ignored.

Reset
REQ-027 Reset SHALL force state BOOT, burst counter 0, LdCount 0, held Instr 0, Stall=1, LdReady=1, MemWE=0.
REQ-028 Reset asserted mid-RUN SHALL abort any grant in the same cycle; no memory write occurs while reset is high.

Configuration
REQ-029 With IMEM_ARB_PERF_EN defined, a 16-bit saturating output StallCycles SHALL count RUN cycles with Stall=1, cleared by reset.
REQ-030 Without IMEM_ARB_PERF_EN, the StallCycles port and counter SHALL not exist.

Structure
REQ-031 A shared package imem_arb_pkg SHALL hold the state enum (BOOT, RUN, DRAIN) and default-width constants.
REQ-032 The grant logic, FSM and burst counter SHALL form a single imem_arb_fsm sub-module; datapath muxing stays in imem_arbiter.

Verification
REQ-033 Load 0x20020005 at addr 0 and 0x2003000C at addr 1, then pulse LdDone -> LdCount=2, Stall=1 for one DRAIN cycle, then with PC=1: Instr=0x2003000C.
REQ-034 LdDone coincident with LdValid (addr 2, 0x2067FFF7) -> the write lands; in RUN, PC=2 gives 0x2067FFF7.
REQ-035 In RUN, LdValid held high for 10 cycles with MAX_BURST=4 -> grant pattern L,L,L,L,F,L,L,L,L,F; Stall low only on F cycles.
REQ-036 In RUN, write 0x00E22025 at addr 3, then PC=3 on the next fetch grant -> Instr=0x00E22025.
REQ-037 Assert reset mid-RUN during a loader grant -> MemWE=0 immediately, state BOOT, LdCount=0, Stall=1.
REQ-038 With IMEM_ARB_PERF_EN defined, repeat REQ-035 -> StallCycles=8.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// ----------------------------------------------------------------------------
// imem_arb_pkg -- state encoding and default widths shared by the arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package imem_arb_pkg;

  localparam int C_DEF_ADDR_W    = 5;
  localparam int C_DEF_DATA_W    = 32;
  localparam int C_DEF_MAX_BURST = 4;

  localparam logic [1:0] C_ST_BOOT  = 2'd0;
  localparam logic [1:0] C_ST_RUN   = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = C_ST_BOOT,
    RUN   = C_ST_RUN,
    DRAIN = C_ST_DRAIN
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_arb_fsm.sv
// ----------------------------------------------------------------------------
// imem_arb_fsm -- boot/drain/run sequencing, loader-vs-fetch grant, burst limit
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_arb_fsm
  import imem_arb_pkg::*;
#(
  parameter int MAX_BURST = C_DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_ld_valid,
  input  logic       i_ld_done,
  output logic [1:0] o_state,
  output logic       o_ld_we,
  output logic       o_ld_ready,
  output logic       o_fetch,
  output logic       o_stall
);

  localparam int              C_BW  = $clog2(MAX_BURST + 1);
  localparam logic [C_BW-1:0] C_MAX = C_BW'(MAX_BURST);

  arb_state_e      r_state;
  logic [C_BW-1:0] r_burst;
  logic            w_ld_grant;
  logic            w_fetch;

  always_comb begin
    w_ld_grant = 1'b0;
    w_fetch    = 1'b0;
    case (r_state)
      BOOT: w_ld_grant = i_ld_valid;
      RUN: begin
        w_ld_grant = i_ld_valid && (r_burst < C_MAX);
        w_fetch    = !w_ld_grant;
      end
      default: ;
    endcase
  end

  // Reset is folded in combinationally so no write can slip out while it is high.
  assign o_ld_we    = w_ld_grant && !i_rst;
  assign o_ld_ready = (r_state == BOOT) || ((r_state == RUN) && w_ld_grant);
  assign o_fetch    = w_fetch;
  assign o_stall    = !w_fetch;
  assign o_state    = r_state;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BOOT;
      r_burst <= '0;
    end else begin
      case (r_state)
        BOOT:    if (i_ld_done) r_state <= DRAIN;
        DRAIN:   r_state <= RUN;
        RUN:     ;
        default: r_state <= BOOT;
      endcase
      if (w_fetch) begin
        r_burst <= '0;
      end else if ((r_state == RUN) && w_ld_grant) begin
        r_burst <= r_burst + C_BW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter -- shares one instruction memory port between a boot loader and
// CPU fetch. Optional stall counter enabled by `define IMEM_ARB_PERF_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W    = C_DEF_ADDR_W,
  parameter int DATA_W    = C_DEF_DATA_W,
  parameter int MAX_BURST = C_DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Instr,
  output logic              Stall,
  input  logic              LdValid,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  output logic              LdReady,
  input  logic              LdDone,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWE,
  input  logic [DATA_W-1:0] MemRData,
  output logic [ADDR_W:0]   LdCount
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [15:0]       StallCycles
`endif
);

  localparam logic [ADDR_W:0] C_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        w_state;
  logic              w_ld_we;
  logic              w_ld_ready;
  logic              w_fetch;
  logic              w_stall;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W:0]   r_ld_count;

  imem_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk        (clk),
    .i_rst      (reset),
    .i_ld_valid (LdValid),
    .i_ld_done  (LdDone),
    .o_state    (w_state),
    .o_ld_we    (w_ld_we),
    .o_ld_ready (w_ld_ready),
    .o_fetch    (w_fetch),
    .o_stall    (w_stall)
  );

  assign MemAddr  = w_fetch ? PC : LdAddr;
  assign MemWData = LdData;
  assign MemWE    = w_ld_we;
  assign LdReady  = w_ld_ready;
  assign Stall    = w_stall;
  assign LdCount  = r_ld_count;
  assign Instr    = (w_state == C_ST_BOOT) ? '0 :
                    w_fetch                ? MemRData : r_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_ld_count <= '0;
    end else begin
      if (w_fetch) r_instr <= MemRData;
      if (LdValid && w_ld_ready && (r_ld_count != C_COUNT_MAX)) begin
        r_ld_count <= r_ld_count + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((w_state == C_ST_RUN) && w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
